// File: rtl/tag_pkg.sv
// Shared encodings and FSM state type for the tag broker and its release path.
package tag_pkg;

  // A cleared BM_CONTROL bit requests the action; both set means the allocator is left alone.
  localparam logic [1:0] FL_CLAIM_IDLE = 2'b01;
  localparam logic [1:0] FL_FREE_IDLE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLAIM  = 2'd1,
    SETTLE = 2'd2
  } state_e;

endpackage

// File: rtl/tag_release_fifo.sv
// Small synchronous FIFO holding returned tags until the broker can hand them back.
module tag_release_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tag_broker.sv
// Arbitrates tag claims and queued tag returns onto a single bitmap allocator port,
// one grant at most every three cycles, never claiming and freeing in the same cycle.
module tag_broker
  import tag_pkg::*;
#(
  parameter  int LIST_SIZE = 32,
  parameter  int REL_DEPTH = 4,
  localparam int W         = $clog2(LIST_SIZE)
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         alloc_req_i,
  output logic         alloc_gnt_o,
  output logic [W-1:0] alloc_tag_o,
  input  logic         release_valid_i,
  input  logic [W-1:0] release_tag_i,
  output logic         release_ready_o,
  input  logic [W-1:0] bm_available_i,
  input  logic         bm_valid_i,
  output logic [W-1:0] bm_claim_o,
  output logic [W-1:0] bm_free_o,
  output logic [1:0]   bm_control_o,
  output logic [W:0]   outstanding_o
);

  localparam logic [W:0] LIST_MAX = (W+1)'(LIST_SIZE);

  state_e       state_q, state_d;
  logic [W-1:0] tag_q, tag_d;
  logic [W:0]   outstanding_q, outstanding_d;
  logic         claim, drain;
  logic         rel_in_range, rel_push;
  logic         fifo_full, fifo_empty;
  logic [W-1:0] fifo_head;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: begin
        if (alloc_req_i && bm_valid_i) begin
          state_d = CLAIM;
          tag_d   = bm_available_i;
        end
      end
      CLAIM:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Qualifying with reset lets a reset landing on CLAIM abort the grant outright.
  assign claim = rstn_i && (state_q == CLAIM);
  assign drain = rstn_i && !fifo_empty && (state_q != CLAIM);

  assign rel_in_range    = ({1'b0, release_tag_i} < LIST_MAX);
  assign release_ready_o = !fifo_full;
  assign rel_push        = release_valid_i && release_ready_o && rel_in_range;

  tag_release_fifo #(
    .WIDTH (W),
    .DEPTH (REL_DEPTH)
  ) u_release_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (rel_push),
    .data_i  (release_tag_i),
    .pop_i   (drain),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    if (claim && !drain && (outstanding_q < LIST_MAX)) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (drain && !claim && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  assign alloc_gnt_o   = claim;
  assign alloc_tag_o   = claim ? tag_q : '0;
  assign bm_claim_o    = claim ? tag_q : '0;
  assign bm_free_o     = drain ? fifo_head : '0;
  assign bm_control_o  = (claim ? 2'b00 : FL_CLAIM_IDLE) | (drain ? 2'b00 : FL_FREE_IDLE);
  assign outstanding_o = outstanding_q;

endmodule
